csr_trap_unit: RTL
==================

CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 Parameter NUM_PLAT_IRQ, 4: number of platform interrupt lines, mapped to mip/mie bits 16..16+NUM_PLAT_IRQ-1 (range 0..16).
REQ-002 Parameter CNT_WIDTH, 64: mcycle/minstret width (range 33..64).
REQ-003 Parameter RESET_MTVEC, 32'h0000_0000: mtvec reset value.
REQ-004 Clock and reset SHALL be as decided: reset i_rst_n, asynchronous, active-low; clock i_clk.
REQ-005 Ports (name direction width meaning):
- i_clk in 1 clock
- i_rst_n in 1 async active-low reset
- i_ce in 1 stage valid
- i_stall in 1 pipeline stall
- i_ext_irq / i_sw_irq / i_tmr_irq in 1 each: MEIP / MSIP / MTIP sources
- i_plat_irq in NUM_PLAT_IRQ: platform interrupt lines, level
- i_is_illegal / i_is_ecall / i_is_ebreak / i_is_mret in 1 each: decoder flags
- i_ld_misalign / i_st_misalign in 1 each: misaligned access flags
- i_fault_addr in 32: misaligned address
- i_funct3 in 3: CSR op
- i_csr_index in 12: CSR address
- i_rs1 in 32: register operand
- i_zimm in 5: immediate operand
- i_src_zero in 1: rs1 index or zimm is zero
- o_csr_rdata out 32: old CSR value for rd
- o_csr_illegal out 1: CSR access illegal (combinational)
- i_pc in 32: PC of current instruction
- i_wb_change_pc in 1: writeback flush, overrides this stage
- i_minstret_inc in 1: instruction retired
- o_go_to_trap_q out 1: trap entry pulse
- o_return_from_trap_q out 1: mret pulse
- o_trap_address out 32: trap target
- o_return_address out 32: mepc

Function
REQ-006 Stage is active when i_ce & !i_stall & !i_wb_change_pc; no CSR, trap or FSM state changes otherwise (counters excepted).
REQ-007 funct3 001/010/011 = RW/RS/RC using i_rs1; 101/110/111 same using zero-extended i_zimm; RS/RC with i_src_zero SHALL not write.
REQ-008 Implemented CSRs: mvendorid, marchid, mimpid, mhartid (read-only, value 0), misa (read-only 32'h4000_0100), mstatus (MIE bit 3, MPIE bit 7, MPP bits 12:11 fixed 2'b11), mie, mip (read-only from sources), mtvec, mscratch, mepc (bits 1:0 zero), mcause, mtval.
REQ-009 Unimplemented index, or write to index[11:10]==2'b11, SHALL assert o_csr_illegal, read 0, write nothing; o_csr_illegal is treated as an exception with cause 2.
REQ-010 Exception priority: illegal (2) > ebreak (3) > ecall (11) > load misaligned (4) > store misaligned (6); mtval = i_fault_addr for 4/6, else 0.
REQ-011 Interrupt taken only if mstatus.MIE and mie bit set; priority MEI (11) > MSI (3) > MTI (7) > platform lowest index first (16+k); mcause[31]=1.
REQ-012 Exceptions SHALL take precedence over interrupts; any trap SHALL take precedence over mret and CSR write in the same cycle (write suppressed).
REQ-013 FSM states IDLE, TRAP, RET: IDLE->TRAP on trap detected; IDLE->RET on mret; TRAP/RET->IDLE next cycle unconditionally.
REQ-014 Latency: trap detected at edge N sets mepc=i_pc, mcause, mtval, MPIE=MIE, MIE=0, o_go_to_trap_q=1 for exactly one cycle (state TRAP).
REQ-015 mret at edge N sets MIE=MPIE, MPIE=1, o_return_from_trap_q=1 for one cycle (state RET).
REQ-016 No new trap detected while in TRAP or RET.
REQ-017 o_trap_address = mtvec base (bits 31:2) when mtvec[1:0]=00, or base+4*cause for interrupts when 01; exceptions always use base; mtvec[1:0]=1x writes SHALL be stored as 00.
REQ-018 o_return_address SHALL always equal mepc.

Reset
REQ-019 On reset all CSRs 0 except mtvec=RESET_MTVEC and misa; FSM=IDLE; o_go_to_trap_q=o_return_from_trap_q=0; reset mid-pulse SHALL clear pulses immediately.

Configuration
REQ-020 Macro CSR_COUNTERS_EN defined: mcycle (0xB00/0xB80), minstret (0xB02/0xB82), read-only shadows cycle/instret (0xC00/0xC80/0xC02/0xC82); mcycle +1 every cycle, minstret +1 on i_minstret_inc, wrap to 0; a CSR write in the same cycle overrides the increment; high halves read bits CNT_WIDTH-1:32 zero-extended.
REQ-021 Macro not defined: counter addresses read 0, writes ignored, not illegal.

Structure
REQ-022 Package csr_pkg SHALL hold CSR address constants, cause codes, funct3 op codes and the FSM state enum.
REQ-023 Sub-module csr_counter (width CNT_WIDTH, inc, write low/high) SHALL be instantiated once per counter under CSR_COUNTERS_EN.

Verification
REQ-024 mtvec=0x100 mode 01, mie[11]=1, MIE=1, i_ext_irq=1, pc=0x40 -> next cycle o_go_to_trap_q=1, mcause=0x8000_000B, mepc=0x40, o_trap_address=0x12C, MIE=0, MPIE=1.
REQ-025 i_is_ecall and i_ext_irq together -> mcause=11, o_trap_address=0x100.
REQ-026 i_is_mret after trap -> o_return_from_trap_q one cycle, MIE=1, o_return_address=0x40.
REQ-027 CSRRS mscratch with i_src_zero=1 -> rdata old value, no write; CSRRW 0xF11 -> o_csr_illegal=1, trap cause 2.
REQ-028 With CSR_COUNTERS_EN: write mcycle low=0xFFFF_FFFF -> high half increments to 1 next cycle; trap with i_wb_change_pc=1 -> no pulse, CSRs unchanged.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR / trap unit.
//   - CSR addresses of every implemented register (and the optional counters)
//   - exception / interrupt cause codes
//   - funct3 CSR operation encodings
//   - trap FSM state enum
//   - csr_apply(): read-modify-write helper for RW/RS/RC
package csr_pkg;

  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  // Exception cause codes (mcause[31] = 0)
  localparam logic [4:0] CAUSE_ILLEGAL_INSN = 5'd2;
  localparam logic [4:0] CAUSE_BREAKPOINT   = 5'd3;
  localparam logic [4:0] CAUSE_LD_MISALIGN  = 5'd4;
  localparam logic [4:0] CAUSE_ST_MISALIGN  = 5'd6;
  localparam logic [4:0] CAUSE_ECALL_M      = 5'd11;

  // Interrupt cause codes (mcause[31] = 1); platform line k uses 16+k
  localparam logic [4:0] IRQ_MSI      = 5'd3;
  localparam logic [4:0] IRQ_MTI      = 5'd7;
  localparam logic [4:0] IRQ_MEI      = 5'd11;
  localparam int unsigned IRQ_PLAT_BASE = 16;

  // funct3[1:0] selects the operation, funct3[2] selects zimm over rs1
  localparam logic [1:0] CSR_OP_NONE = 2'b00;
  localparam logic [1:0] CSR_OP_RW   = 2'b01;
  localparam logic [1:0] CSR_OP_RS   = 2'b10;
  localparam logic [1:0] CSR_OP_RC   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRAP = 2'd1,
    ST_RET  = 2'd2
  } trap_state_e;

  function automatic logic [31:0] csr_apply(input logic [1:0]  op,
                                            input logic [31:0] old_v,
                                            input logic [31:0] src);
    case (op)
      CSR_OP_RW: csr_apply = src;
      CSR_OP_RS: csr_apply = old_v | src;
      CSR_OP_RC: csr_apply = old_v & ~src;
      default:   csr_apply = old_v;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running WIDTH-bit counter with 32-bit low/high write ports.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   inc_i          : add one this cycle (wraps to zero)
//   wr_lo_i        : load bits 31:0 from wdata_i
//   wr_hi_i        : load bits WIDTH-1:32 from wdata_i
//   wdata_i        : write data
//   cnt_o          : current count
// A write in the same cycle as an increment wins; the increment is dropped.
module csr_counter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             inc_i,
  input  logic             wr_lo_i,
  input  logic             wr_hi_i,
  input  logic [31:0]      wdata_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i) begin
      cnt_d[31:0] = wdata_i;
    end else if (wr_hi_i) begin
      cnt_d[WIDTH-1:32] = wdata_i[WIDTH-33:0];
    end else if (inc_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller.
// Executes Zicsr instructions against the implemented M-mode CSRs, detects
// exceptions and interrupts, and sequences trap entry / mret through a small
// IDLE/TRAP/RET FSM whose state doubles as the one-cycle output pulses.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_ce, i_stall           stage valid / stall
//   i_wb_change_pc          writeback flush; kills this stage
//   i_ext_irq/i_sw_irq/i_tmr_irq, i_plat_irq   interrupt sources (level)
//   i_is_illegal/ecall/ebreak/mret, i_ld/st_misalign, i_fault_addr  decoder flags
//   i_funct3, i_csr_index, i_rs1, i_zimm, i_src_zero   CSR instruction fields
//   o_csr_rdata, o_csr_illegal   old CSR value for rd / access illegal (comb.)
//   i_pc, i_minstret_inc     current PC / retire strobe
//   o_go_to_trap_q, o_return_from_trap_q   one-cycle trap / mret pulses
//   o_trap_address, o_return_address        trap target / mepc
//   o_fsm_state              trap FSM state (debug)
//
// Build option: define CSR_COUNTERS_EN to implement mcycle/minstret and
// their cycle/instret shadows; otherwise those addresses read as zero and
// ignore writes.
//
// Handshake: the stage acts only when i_ce=1, i_stall=0 and i_wb_change_pc=0
// and the FSM is IDLE; any other cycle leaves CSRs and FSM untouched
// (counters still count).
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int unsigned NUM_PLAT_IRQ = 4,
  parameter int unsigned CNT_WIDTH    = 64,
  parameter logic [31:0] RESET_MTVEC  = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ce,
  input  logic        i_stall,
  input  logic        i_ext_irq,
  input  logic        i_sw_irq,
  input  logic        i_tmr_irq,
  input  logic [((NUM_PLAT_IRQ > 0) ? NUM_PLAT_IRQ : 1)-1:0] i_plat_irq,
  input  logic        i_is_illegal,
  input  logic        i_is_ecall,
  input  logic        i_is_ebreak,
  input  logic        i_is_mret,
  input  logic        i_ld_misalign,
  input  logic        i_st_misalign,
  input  logic [31:0] i_fault_addr,
  input  logic [2:0]  i_funct3,
  input  logic [11:0] i_csr_index,
  input  logic [31:0] i_rs1,
  input  logic [4:0]  i_zimm,
  input  logic        i_src_zero,
  output logic [31:0] o_csr_rdata,
  output logic        o_csr_illegal,
  input  logic [31:0] i_pc,
  input  logic        i_wb_change_pc,
  input  logic        i_minstret_inc,
  output logic        o_go_to_trap_q,
  output logic        o_return_from_trap_q,
  output logic [31:0] o_trap_address,
  output logic [31:0] o_return_address,
  output logic [1:0]  o_fsm_state
);

  localparam logic [31:0] PLAT_MASK = ((32'h1 << NUM_PLAT_IRQ) - 32'h1) << IRQ_PLAT_BASE;
  localparam logic [31:0] MIE_MASK  = PLAT_MASK | 32'h0000_0888;

  trap_state_e state_q, state_d;
  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;

  logic        active, idle;
  logic [1:0]  csr_op;
  logic        is_csr, wr_attempt, csr_known, csr_illegal, csr_we;
  logic [31:0] csr_src, rdata_raw, csr_wdata;
  logic [31:0] mip_val, mstatus_val, irq_pend;
  logic        exc_valid, irq_valid, take_trap, do_mret;
  logic [4:0]  exc_code, irq_code, plat_code;
  logic        plat_any;
  logic [31:0] cyc_lo, cyc_hi, ins_lo, ins_hi;

  assign active = i_ce & ~i_stall & ~i_wb_change_pc;
  assign idle   = (state_q == ST_IDLE);

  assign csr_op     = i_funct3[1:0];
  assign is_csr     = (csr_op != CSR_OP_NONE);
  assign csr_src    = i_funct3[2] ? {27'b0, i_zimm} : i_rs1;
  // RS/RC with a zero source are pure reads and may touch read-only CSRs
  assign wr_attempt = is_csr & ((csr_op == CSR_OP_RW) | ~i_src_zero);

  always_comb begin
    mip_val     = 32'b0;
    mip_val[3]  = i_sw_irq;
    mip_val[7]  = i_tmr_irq;
    mip_val[11] = i_ext_irq;
    for (int k = 0; k < NUM_PLAT_IRQ; k++) mip_val[IRQ_PLAT_BASE + k] = i_plat_irq[k];
  end

  assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};

  // Counters
`ifdef CSR_COUNTERS_EN
  logic [CNT_WIDTH-1:0] mcycle, minstret;

  csr_counter #(.WIDTH(CNT_WIDTH)) u_mcycle (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .inc_i   (1'b1),
    .wr_lo_i (csr_we && (i_csr_index == CSR_MCYCLE)),
    .wr_hi_i (csr_we && (i_csr_index == CSR_MCYCLEH)),
    .wdata_i (csr_wdata),
    .cnt_o   (mcycle)
  );

  csr_counter #(.WIDTH(CNT_WIDTH)) u_minstret (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .inc_i   (i_minstret_inc),
    .wr_lo_i (csr_we && (i_csr_index == CSR_MINSTRET)),
    .wr_hi_i (csr_we && (i_csr_index == CSR_MINSTRETH)),
    .wdata_i (csr_wdata),
    .cnt_o   (minstret)
  );

  assign cyc_lo = mcycle[31:0];
  assign cyc_hi = 32'(mcycle[CNT_WIDTH-1:32]);
  assign ins_lo = minstret[31:0];
  assign ins_hi = 32'(minstret[CNT_WIDTH-1:32]);
`else
  logic unused_counters;
  assign unused_counters = i_minstret_inc;
  assign cyc_lo = 32'b0;
  assign cyc_hi = 32'b0;
  assign ins_lo = 32'b0;
  assign ins_hi = 32'b0;
`endif

  // CSR read mux
  always_comb begin
    csr_known = 1'b1;
    rdata_raw = 32'b0;
    case (i_csr_index)
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: rdata_raw = 32'b0;
      CSR_MISA:                    rdata_raw = MISA_VALUE;
      CSR_MSTATUS:                 rdata_raw = mstatus_val;
      CSR_MIE:                     rdata_raw = mie_q;
      CSR_MIP:                     rdata_raw = mip_val;
      CSR_MTVEC:                   rdata_raw = mtvec_q;
      CSR_MSCRATCH:                rdata_raw = mscratch_q;
      CSR_MEPC:                    rdata_raw = mepc_q;
      CSR_MCAUSE:                  rdata_raw = mcause_q;
      CSR_MTVAL:                   rdata_raw = mtval_q;
      CSR_MCYCLE, CSR_CYCLE:       rdata_raw = cyc_lo;
      CSR_MCYCLEH, CSR_CYCLEH:     rdata_raw = cyc_hi;
      CSR_MINSTRET, CSR_INSTRET:   rdata_raw = ins_lo;
      CSR_MINSTRETH, CSR_INSTRETH: rdata_raw = ins_hi;
      default:                     csr_known = 1'b0;
    endcase
  end

  assign csr_illegal   = is_csr & (~csr_known | (wr_attempt & (i_csr_index[11:10] == 2'b11)));
  assign o_csr_illegal = csr_illegal;
  assign o_csr_rdata   = csr_illegal ? 32'b0 : rdata_raw;
  assign csr_wdata     = csr_apply(csr_op, rdata_raw, csr_src);

  // Exception detection, highest priority first
  always_comb begin
    exc_valid = 1'b1;
    exc_code  = CAUSE_ILLEGAL_INSN;
    if (i_is_illegal | csr_illegal) exc_code = CAUSE_ILLEGAL_INSN;
    else if (i_is_ebreak)           exc_code = CAUSE_BREAKPOINT;
    else if (i_is_ecall)            exc_code = CAUSE_ECALL_M;
    else if (i_ld_misalign)         exc_code = CAUSE_LD_MISALIGN;
    else if (i_st_misalign)         exc_code = CAUSE_ST_MISALIGN;
    else                            exc_valid = 1'b0;
  end

  // Interrupt selection: MEI > MSI > MTI > platform (lowest line first)
  assign irq_pend = mip_val & mie_q;

  always_comb begin
    plat_any  = 1'b0;
    plat_code = 5'd0;
    // Descending scan so the lowest pending line is the last one assigned
    for (int k = NUM_PLAT_IRQ - 1; k >= 0; k--) begin
      if (irq_pend[IRQ_PLAT_BASE + k]) begin
        plat_any  = 1'b1;
        plat_code = 5'(IRQ_PLAT_BASE + k);
      end
    end
  end

  always_comb begin
    irq_code = plat_code;
    if (irq_pend[11])     irq_code = IRQ_MEI;
    else if (irq_pend[3]) irq_code = IRQ_MSI;
    else if (irq_pend[7]) irq_code = IRQ_MTI;
  end

  assign irq_valid = mstatus_mie_q & (irq_pend[11] | irq_pend[3] | irq_pend[7] | plat_any);
  assign take_trap = active & idle & (exc_valid | irq_valid);
  assign do_mret   = active & idle & i_is_mret & ~take_trap;
  assign csr_we    = active & idle & wr_attempt & ~csr_illegal & ~take_trap;

  // Next-state for FSM and CSRs
  always_comb begin
    state_d        = ST_IDLE;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;

    if (take_trap) begin
      state_d        = ST_TRAP;
      mepc_d         = i_pc & 32'hFFFF_FFFC;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      if (exc_valid) begin
        mcause_d = {27'b0, exc_code};
        mtval_d  = ((exc_code == CAUSE_LD_MISALIGN) || (exc_code == CAUSE_ST_MISALIGN))
                   ? i_fault_addr : 32'b0;
      end else begin
        mcause_d = {1'b1, 26'b0, irq_code};
        mtval_d  = 32'b0;
      end
    end else if (do_mret) begin
      state_d        = ST_RET;
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (csr_we) begin
      case (i_csr_index)
        CSR_MSTATUS: begin
          mstatus_mie_d  = csr_wdata[3];
          mstatus_mpie_d = csr_wdata[7];
        end
        CSR_MIE:      mie_d      = csr_wdata & MIE_MASK;
        // Reserved modes (1x) fall back to direct mode
        CSR_MTVEC:    mtvec_d    = {csr_wdata[31:2], csr_wdata[1] ? 2'b00 : csr_wdata[1:0]};
        CSR_MSCRATCH: mscratch_d = csr_wdata;
        CSR_MEPC:     mepc_d     = csr_wdata & 32'hFFFF_FFFC;
        CSR_MCAUSE:   mcause_d   = csr_wdata;
        CSR_MTVAL:    mtval_d    = csr_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= ST_IDLE;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'b0;
      mtvec_q        <= RESET_MTVEC;
      mscratch_q     <= 32'b0;
      mepc_q         <= 32'b0;
      mcause_q       <= 32'b0;
      mtval_q        <= 32'b0;
    end else begin
      state_q        <= state_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
    end
  end

  // Pulses come straight from the state register, so reset clears them at once
  assign o_go_to_trap_q       = (state_q == ST_TRAP);
  assign o_return_from_trap_q = (state_q == ST_RET);
  assign o_fsm_state          = state_q;
  assign o_return_address     = mepc_q;

  // Vectoring applies to interrupts only; exceptions always land on the base
  always_comb begin
    o_trap_address = {mtvec_q[31:2], 2'b00};
    if ((mtvec_q[1:0] == 2'b01) && mcause_q[31]) begin
      o_trap_address = {mtvec_q[31:2], 2'b00} + {mcause_q[29:0], 2'b00};
    end
  end

endmodule
